// File: rtl/multi_averaging_decim_pkg.sv
// Shared definitions for the multi-channel averaging decimator: mode encoding
// and the default largest log2 decimation rate.
package multi_averaging_decim_pkg;

    localparam int LOG2_MAX_DEF = 8;

    typedef enum logic {
        MODE_AVG = 1'b0,
        MODE_SUM = 1'b1
    } mode_e;

endpackage

// File: rtl/multi_averaging_decim_if.sv
// Sample stream into and decimated stream out of the decimator.
// The block uses the slave modport; the producer/consumer uses master.
interface multi_averaging_decim_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CHAN   = 2
);
    logic                           strobe_in;
    logic [NUM_CHAN*DATA_WIDTH-1:0] data_in;
    logic                           strobe_out;
    logic [NUM_CHAN*DATA_WIDTH-1:0] data_out;

    modport master (output strobe_in, output data_in, input strobe_out, input data_out);
    modport slave  (input strobe_in, input data_in, output strobe_out, output data_out);
endinterface

// File: rtl/averaging_decim_chan.sv
// One channel: accumulate, then round/shift (average) or saturate (sum) at the
// end of a block. Block sequencing comes from the shared control in the top.
module averaging_decim_chan
    import multi_averaging_decim_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_MAX   = LOG2_MAX_DEF,
    parameter int RATE_WIDTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         accept,
    input  logic                         last,
    input  logic [RATE_WIDTH-1:0]        rate,
    input  mode_e                        mode,
    input  logic [DATA_WIDTH-1:0]        sample,
    output logic [DATA_WIDTH-1:0]        result,
    output logic                         clip
);
    localparam int ACC_W = DATA_WIDTH + LOG2_MAX;
    localparam int RND_W = ACC_W + 1;

    logic signed [ACC_W-1:0]        acc;
    logic signed [ACC_W-1:0]        sum;
    logic signed [RND_W-1:0]        sum_ext;
    logic signed [RND_W-1:0]        bias;
    logic signed [RND_W-1:0]        shifted;
    logic signed [RND_W-1:0]        sel;
    logic [RND_W-DATA_WIDTH:0]      hi;
    logic                           ovf;
    logic [DATA_WIDTH-1:0]          sat;

    assign sum     = acc + {{LOG2_MAX{sample[DATA_WIDTH-1]}}, sample};
    assign sum_ext = {sum[ACC_W-1], sum};
    assign bias    = (rate == '0) ? '0 : (RND_W'(1) << (rate - 1'b1));
    assign shifted = (sum_ext + bias) >>> rate;

    // Average results always fit, so one saturator serves both modes and
    // only flags a clip in sum mode.
    assign sel = (mode == MODE_SUM) ? sum_ext : shifted;
    assign hi  = sel[RND_W-1:DATA_WIDTH-1];
    assign ovf = ~((&hi) | ~(|hi));
    assign sat = ovf ? (sel[RND_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                     : {1'b0, {(DATA_WIDTH-1){1'b1}}})
                     : sel[DATA_WIDTH-1:0];

    assign clip = accept & last & (mode == MODE_SUM) & ovf;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc    <= '0;
            result <= '0;
        end else if (flush) begin
            acc <= '0;
        end else if (accept) begin
            if (last) begin
                acc    <= '0;
                result <= sat;
            end else begin
                acc <= sum;
            end
        end
    end
endmodule

// File: rtl/multi_averaging_decim.sv
// Multi-channel block averager/decimator by 2^log2rate with shared sample
// counter, per-block rate/mode latching and a sticky saturation flag.
module multi_averaging_decim
    import multi_averaging_decim_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CHAN   = 2,
    parameter int LOG2_MAX   = LOG2_MAX_DEF,
    parameter int RATE_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [RATE_WIDTH-1:0] log2rate,
    input  logic                  mode,
    input  logic                  clear_sat,
    multi_averaging_decim_if.slave bus,
    output logic                  sat_flag
);
    logic [LOG2_MAX-1:0]                 count;
    logic [LOG2_MAX-1:0]                 last_cnt;
    logic [RATE_WIDTH-1:0]               rate_q;
    logic [RATE_WIDTH-1:0]               rate_clamp;
    logic [RATE_WIDTH-1:0]               rate_eff;
    mode_e                               mode_q;
    mode_e                               mode_eff;
    logic                                accept;
    logic                                first;
    logic                                last;
    logic                                strobe_q;
    logic [NUM_CHAN-1:0]                 clip;
    logic [NUM_CHAN-1:0][DATA_WIDTH-1:0] sample_vec;
    logic [NUM_CHAN-1:0][DATA_WIDTH-1:0] result_vec;

    assign accept     = enable & bus.strobe_in;
    assign first      = (count == '0);
    assign rate_clamp = (log2rate > RATE_WIDTH'(LOG2_MAX)) ? RATE_WIDTH'(LOG2_MAX) : log2rate;

    // The first sample of a block uses the live settings, later ones the latched copy.
    assign rate_eff = first ? rate_clamp : rate_q;
    assign mode_eff = first ? mode_e'(mode) : mode_q;
    assign last_cnt = ~({LOG2_MAX{1'b1}} << rate_eff);
    assign last     = (count == last_cnt);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            rate_q   <= '0;
            mode_q   <= MODE_AVG;
            strobe_q <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            strobe_q <= accept & last;
            sat_flag <= (|clip) | (sat_flag & ~clear_sat);
            if (!enable) begin
                count <= '0;
            end else if (accept) begin
                if (first) begin
                    rate_q <= rate_clamp;
                    mode_q <= mode_eff;
                end
                count <= last ? '0 : count + LOG2_MAX'(1);
            end
        end
    end

    assign sample_vec     = bus.data_in;
    assign bus.data_out   = result_vec;
    assign bus.strobe_out = strobe_q;

    for (genvar k = 0; k < NUM_CHAN; k++) begin : g_chan
        averaging_decim_chan #(
            .DATA_WIDTH (DATA_WIDTH),
            .LOG2_MAX   (LOG2_MAX),
            .RATE_WIDTH (RATE_WIDTH)
        ) u_chan (
            .clock  (clock),
            .reset  (reset),
            .flush  (~enable),
            .accept (accept),
            .last   (last),
            .rate   (rate_eff),
            .mode   (mode_eff),
            .sample (sample_vec[k]),
            .result (result_vec[k]),
            .clip   (clip[k])
        );
    end
endmodule

// File: tb/tb_multi_averaging_decim.sv
// Directed bench for multi_averaging_decim: a table of single blocks with
// hand-computed outputs plus sequences for rate change, reset and enable.
module tb_multi_averaging_decim;
    import multi_averaging_decim_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] log2rate = '0;
    logic       mode = MODE_AVG;
    logic       clear_sat = 1'b0;
    logic       sat_flag;
    int         errors = 0;
    int         checks = 0;

    multi_averaging_decim_if #(.DATA_WIDTH(16), .NUM_CHAN(2)) bus ();

    multi_averaging_decim #(
        .DATA_WIDTH (16),
        .NUM_CHAN   (2),
        .LOG2_MAX   (LOG2_MAX_DEF),
        .RATE_WIDTH (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .log2rate  (log2rate),
        .mode      (mode),
        .clear_sat (clear_sat),
        .bus       (bus),
        .sat_flag  (sat_flag)
    );

    always #5 clock = ~clock;

    typedef struct {
        string name;
        int    rate;
        logic  md;
        int    n;
        int    gap;
        int    b0, s0, b1, s1;
        int    e0, e1;
        int    esat;
    } vec_t;

    vec_t tab[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int out0();
        return int'($signed(bus.data_out[15:0]));
    endfunction

    function automatic int out1();
        return int'($signed(bus.data_out[31:16]));
    endfunction

    // Drive one cycle of input, then sample #1 after the edge.
    task automatic step(input logic stb, input int d0, input int d1);
        logic [15:0] v0, v1;
        v0 = 16'(d0);
        v1 = 16'(d1);
        bus.strobe_in = stb;
        bus.data_in   = {v1, v0};
        @(posedge clock);
        #1;
        bus.strobe_in = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        clear_sat = 1'b1;
        step(1'b0, 0, 0);
        clear_sat = 1'b0;
        log2rate = 4'(v.rate);
        mode     = v.md;
        for (int i = 0; i < v.n; i++) begin
            step(1'b1, v.b0 + i * v.s0, v.b1 + i * v.s1);
            chk({v.name, " strobe"}, int'(bus.strobe_out), (i == v.n - 1) ? 1 : 0);
            for (int g = 0; g < v.gap; g++) begin
                step(1'b0, 0, 0);
                if (g == 0) chk({v.name, " gap strobe"}, int'(bus.strobe_out), 0);
            end
        end
        chk({v.name, " ch0"}, out0(), v.e0);
        chk({v.name, " ch1"}, out1(), v.e1);
        chk({v.name, " sat"}, int'(sat_flag), v.esat);
    endtask

    initial begin
        int nstb;
        bus.strobe_in = 1'b0;
        bus.data_in   = '0;

        tab[0] = '{"avg r2 ramp", 2, MODE_AVG, 4, 0, 1, 1, -1, -1, 3, -2, 0};
        tab[1] = '{"avg r0", 0, MODE_AVG, 1, 0, 1234, 0, -7, 0, 1234, -7, 0};
        tab[2] = '{"avg r1 half", 1, MODE_AVG, 2, 1, 3, 1, -3, -1, 4, -3, 0};
        tab[3] = '{"sum pos clip", 2, MODE_SUM, 4, 0, 20000, 0, -100, 0, 32767, -400, 1};
        tab[4] = '{"sum neg clip", 2, MODE_SUM, 4, 2, -20000, 0, 5, 0, -32768, 20, 1};
        tab[5] = '{"sum r3", 3, MODE_SUM, 8, 0, 1000, 0, -1, -1, 8000, -36, 0};
        tab[6] = '{"avg r8 full", 8, MODE_AVG, 256, 0, 32767, 0, -32768, 0, 32767, -32768, 0};
        tab[7] = '{"avg r12 clamp", 12, MODE_AVG, 256, 0, 0, 1, 100, 0, 128, 100, 0};
        tab[8] = '{"avg r4 mixed", 4, MODE_AVG, 16, 1, -8, 1, 1, 0, 0, 1, 0};

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("reset strobe", int'(bus.strobe_out), 0);
        chk("reset data", int'(bus.data_out), 0);
        chk("reset sat", int'(sat_flag), 0);
        reset  = 1'b1;
        enable = 1'b1;
        step(1'b0, 0, 0);

        foreach (tab[i]) run_vec(tab[i]);

        // Ten blocks of 8 at one strobe per three cycles, constant input
        log2rate = 4'd3;
        mode     = MODE_AVG;
        nstb     = 0;
        for (int i = 0; i < 80; i++) begin
            step(1'b1, 100, -100);
            if (bus.strobe_out) begin
                nstb++;
                chk("drift ch0", out0(), 100);
                chk("drift ch1", out1(), -100);
            end
            for (int g = 0; g < 2; g++) begin
                step(1'b0, 0, 0);
                if (bus.strobe_out) nstb++;
            end
        end
        chk("drift blocks", nstb, 10);

        // Clip on the same edge as clear_sat: the set wins
        log2rate = 4'd2;
        mode     = MODE_SUM;
        for (int i = 0; i < 4; i++) begin
            clear_sat = (i == 3);
            step(1'b1, 20000, 0);
        end
        clear_sat = 1'b0;
        chk("set over clear", int'(sat_flag), 1);
        chk("set over clear data", out0(), 32767);
        clear_sat = 1'b1;
        step(1'b0, 0, 0);
        clear_sat = 1'b0;
        chk("clear sat", int'(sat_flag), 0);

        // Rate change mid-block applies to the next block
        mode     = MODE_AVG;
        log2rate = 4'd2;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) log2rate = 4'd4;
            step(1'b1, 1, 2);
            chk("rate change strobe", int'(bus.strobe_out), (i == 3 || i == 19) ? 1 : 0);
        end
        chk("rate change ch0", out0(), 1);
        chk("rate change ch1", out1(), 2);

        // Reset mid-block discards the partial block
        log2rate = 4'd2;
        for (int i = 0; i < 3; i++) step(1'b1, 50, 50);
        #2 reset = 1'b0;
        #1;
        chk("async reset data", int'(bus.data_out), 0);
        chk("async reset strobe", int'(bus.strobe_out), 0);
        #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8, -8);
            chk("post reset strobe", int'(bus.strobe_out), (i == 3) ? 1 : 0);
        end
        chk("post reset ch0", out0(), 8);
        chk("post reset ch1", out1(), -8);

        // Enable low flushes the block; data_out holds
        for (int i = 0; i < 2; i++) step(1'b1, 40, 40);
        enable = 1'b0;
        step(1'b1, 40, 40);
        chk("disable strobe", int'(bus.strobe_out), 0);
        chk("disable hold", out0(), 8);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 4, -4);
        chk("flush ch0", out0(), 4);
        chk("flush ch1", out1(), -4);

        // Rate 0: every sample passes straight through at latency 1
        log2rate = 4'd0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 300 * i - 7, -11 * i);
            chk("pass strobe", int'(bus.strobe_out), 1);
            chk("pass ch0", out0(), 300 * i - 7);
            chk("pass ch1", out1(), -11 * i);
        end
        step(1'b0, 0, 0);
        chk("pass idle strobe", int'(bus.strobe_out), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
